// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low {g,f,e,d,c,b,a} segment patterns for hex 0-F, blank pattern, and hex_to_seg(nibble) -> pattern
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_1 = 7'b111_1001;
  localparam logic [6:0] SEG_2 = 7'b010_0100;
  localparam logic [6:0] SEG_3 = 7'b011_0000;
  localparam logic [6:0] SEG_4 = 7'b001_1001;
  localparam logic [6:0] SEG_5 = 7'b001_0010;
  localparam logic [6:0] SEG_6 = 7'b000_0010;
  localparam logic [6:0] SEG_7 = 7'b111_1000;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b001_1000;
  localparam logic [6:0] SEG_A = 7'b000_1000;
  localparam logic [6:0] SEG_B = 7'b000_0011;
  localparam logic [6:0] SEG_C = 7'b100_0110;
  localparam logic [6:0] SEG_D = 7'b010_0001;
  localparam logic [6:0] SEG_E = 7'b000_0110;
  localparam logic [6:0] SEG_F = 7'b000_1110;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    return SEG_LUT[v];
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display bus; master drives i_w_data/i_w_dp/i_w_blank/i_w_load, slave drives o_w_7seg/o_w_dp/o_w_an/o_w_frame
interface seg7_scan_driver_if #(parameter int DIGITS = 8);
  logic [4*DIGITS-1:0] i_w_data;
  logic [DIGITS-1:0] i_w_dp;
  logic [DIGITS-1:0] i_w_blank;
  logic i_w_load;
  logic [6:0] o_w_7seg;
  logic o_w_dp;
  logic [DIGITS-1:0] o_w_an;
  logic o_w_frame;
  modport master (output i_w_data, i_w_dp, i_w_blank, i_w_load, input o_w_7seg, o_w_dp, o_w_an, o_w_frame);
  modport slave (input i_w_data, i_w_dp, i_w_blank, i_w_load, output o_w_7seg, o_w_dp, o_w_an, o_w_frame);
endinterface

// File: rtl/seg7_prescaler.sv
// seg7_prescaler: counts 0..PRESCALE-1 and wraps; ports i_w_clk, i_w_rst_n (sync active-low), o_w_tick (high on last count), o_w_count
module seg7_prescaler #(
  parameter int PRESCALE = 100000,
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1
) (
  input  logic i_w_clk,
  input  logic i_w_rst_n,
  output logic o_w_tick,
  output logic [PW-1:0] o_w_count
);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  assign o_w_tick = o_w_count == LAST;
  always_ff @(posedge i_w_clk) o_w_count <= (!i_w_rst_n || o_w_tick) ? '0 : o_w_count + 1'b1;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-seg driver; ports i_w_clk, i_w_rst_n (sync active-low), bus (slave: shadow load in, registered seg/dp/anode/frame out)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int PRESCALE = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input logic i_w_clk,
  input logic i_w_rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  if (DIGITS < 1 || DIGITS > 16 || BLANK_CYCLES < 0 || PRESCALE < BLANK_CYCLES + 2) begin : g_param_check
    $fatal(1, "seg7_scan_driver: illegal DIGITS/PRESCALE/BLANK_CYCLES");
  end
  logic tick;
  logic [PW-1:0] count;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0] dp_q;
  logic [DIGITS-1:0] blank_q;
  logic dark;
  seg7_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_w_clk  (i_w_clk),
    .i_w_rst_n(i_w_rst_n),
    .o_w_tick (tick),
    .o_w_count(count)
  );
  assign dark = count < BLANK_END || blank_q[idx];
  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      idx <= '0;
      data_q <= '0;
      dp_q <= '0;
      blank_q <= '0;
      bus.o_w_an <= '1;
      bus.o_w_7seg <= SEG_OFF;
      bus.o_w_dp <= 1'b1;
      bus.o_w_frame <= 1'b0;
    end else begin
      if (bus.i_w_load) begin
        data_q <= bus.i_w_data;
        dp_q <= bus.i_w_dp;
        blank_q <= bus.i_w_blank;
      end
      idx <= tick ? (idx == LAST_IDX ? '0 : idx + 1'b1) : idx;
      bus.o_w_frame <= tick && idx == LAST_IDX;
      bus.o_w_an <= dark ? '1 : ~(DIGITS'(1) << idx);
      bus.o_w_7seg <= dark ? SEG_OFF : hex_to_seg(data_q[{idx, 2'b00} +: 4]);
      bus.o_w_dp <= dark || !dp_q[idx];
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed stimulus against a cycle-count reference model of the 4-digit scan driver
module tb_seg7_scan_driver;
  localparam int D = 4;
  localparam int P = 8;
  localparam int B = 2;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  int n = 0;
  string phase = "init";
  logic [15:0] sh_data;
  logic [3:0] sh_dp, sh_blank;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic exp_dp, exp_fr;
  logic [6:0] seg_ref [16] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                               7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                               7'b000_0000, 7'b001_1000, 7'b000_1000, 7'b000_0011,
                               7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110};
  seg7_scan_driver_if #(.DIGITS(D)) bus ();
  seg7_scan_driver #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .i_w_clk  (clk),
    .i_w_rst_n(rst_n),
    .bus      (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%h exp=%h t=%0t n=%0d", phase, tag, got, exp, $time, n);
    end
  endtask
  task automatic cycle(input logic rst, input logic ld, input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank);
    int p, d;
    rst_n = rst;
    bus.i_w_load = ld;
    bus.i_w_data = data;
    bus.i_w_dp = dp;
    bus.i_w_blank = blank;
    @(posedge clk);
    exp_an = 4'hF;
    exp_seg = 7'h7F;
    exp_dp = 1'b1;
    exp_fr = 1'b0;
    if (!rst) begin
      n = 0;
      sh_data = '0;
      sh_dp = '0;
      sh_blank = '0;
    end else begin
      n++;
      p = (n - 1) % P;
      d = ((n - 1) / P) % D;
      if (p >= B && !sh_blank[d]) begin
        exp_an = 4'hF & ~(4'(1) << d);
        exp_seg = seg_ref[4'((sh_data >> (4 * d)) & 16'hF)];
        exp_dp = !sh_dp[d];
      end
      exp_fr = (n % (P * D)) == 0;
      if (ld) begin
        sh_data = data;
        sh_dp = dp;
        sh_blank = blank;
      end
    end
    @(negedge clk);
    check("an", 32'(bus.o_w_an), 32'(exp_an));
    check("seg", 32'(bus.o_w_7seg), 32'(exp_seg));
    check("dp", 32'(bus.o_w_dp), 32'(exp_dp));
    check("frame", 32'(bus.o_w_frame), 32'(exp_fr));
    check("an_onehot", 32'($countones(~bus.o_w_an) <= 1), 32'd1);
  endtask
  task automatic idle(input int cnt, input logic [3:0] blank);
    for (int i = 0; i < cnt; i++) cycle(1'b1, 1'b0, 16'($urandom), 4'($urandom), blank);
  endtask
  initial begin
    int first_on;
    phase = "reset";
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'hFFFF, 4'hF, 4'h0);
    phase = "release";
    first_on = -1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      if (first_on < 0 && bus.o_w_an == 4'b1110) first_on = i;
    end
    check("first_anode_cycle", 32'(first_on), 32'd3);
    phase = "a5c0";
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b1, 1'b1, 16'hA5C0, 4'b0100, 4'h0);
    idle(70, 4'h0);
    phase = "sweep";
    for (int v = 0; v < 16; v++) begin
      cycle(1'b1, 1'b1, {4{4'(v)}}, 4'h0, 4'h0);
      idle(8, 4'h0);
    end
    phase = "blank1010";
    cycle(1'b1, 1'b1, 16'h1234, 4'hF, 4'b1010);
    idle(70, 4'b1010);
    phase = "random";
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(99) != 0), ($urandom_range(7) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
    phase = "mid_reset";
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b1, 1'b1, 16'h9876, 4'hF, 4'h0);
    idle(19, 4'h0);
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    check("reset_an", 32'(bus.o_w_an), 32'hF);
    idle(40, 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display. It latches a packed hex word and scans one digit at a time at a programmable refresh rate, with a blanking gap between digits to suppress ghosting. It decodes the full hex range 0-F, and supports per-digit decimal points and per-digit blanking. It sits between the datapath (e.g. a counter or register file) and the board display pins, and replaces static single-digit decoding.

Parameters:
DIGITS, 8, number of digits/anodes scanned (1..16)
PRESCALE, 100000, clock cycles each digit slot lasts (>= BLANK_CYCLES+2)
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (0 allowed)

Ports:
i_w_clk  input  1  system clock
i_w_rst_n  input  1  synchronous reset, active-low
i_w_data  input  4*DIGITS  packed nibbles; digit k = bits [4k+3:4k]; digit 0 is rightmost
i_w_dp  input  DIGITS  decimal-point enable per digit, active-high
i_w_blank  input  DIGITS  1 = digit k dark (anode stays off for the whole slot)
i_w_load  input  1  1-cycle strobe; captures i_w_data/i_w_dp/i_w_blank into shadow registers
o_w_7seg  output  7  segments {g,f,e,d,c,b,a}, active-low
o_w_dp  output  1  decimal point, active-low
o_w_an  output  DIGITS  anodes, active-low, at most one low
o_w_frame  output  1  1-cycle pulse when the digit index wraps DIGITS-1 -> 0

Behaviour:
- One clock, synchronous active-low reset. All state updates on the rising edge of i_w_clk.
- Reset (i_w_rst_n=0 at an edge):
  - prescaler=0, digit index=0, shadow data/dp/blank=0.
  - o_w_an=all 1s, o_w_7seg=7'h7F, o_w_dp=1, o_w_frame=0.
  - Reset mid-scan aborts the current slot immediately; no partial outputs remain after the edge.
- Shadow capture: on an edge with i_w_load=1, shadow <= inputs. The new value is visible on the outputs from the next cycle, including mid-slot. Without i_w_load, input changes are ignored.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. On wrap, the digit index increments. Index DIGITS-1 wraps to 0, and o_w_frame=1 for exactly the cycle the index becomes 0. With DIGITS=1 the index stays 0 and o_w_frame pulses every PRESCALE cycles.
- Outputs are registered, one cycle of latency from prescaler/index/shadow state.
  - If prescaler < BLANK_CYCLES, or shadow blank[idx]=1: o_w_an=all 1s, o_w_7seg=7'h7F, o_w_dp=1.
  - Otherwise: o_w_an has only bit idx low; o_w_7seg=decode(shadow nibble idx); o_w_dp=~shadow dp[idx].
- Decode table (active-low {g..a}):
  - 0-3: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000
  - 4-7: 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000
  - 8-B: 8=000_0000, 9=001_1000, A=000_1000, b=000_0011
  - C-F: C=100_0110, d=010_0001, E=000_0110, F=000_1110
- Sizing:
  - Prescaler width = $clog2(PRESCALE); index width = $clog2(DIGITS), minimum 1.
  - No arithmetic overflow is possible; compare against PRESCALE-1 and DIGITS-1 explicitly.
  - Parameter violations are caught by an elaboration-time check that causes a fatal error.
- Simultaneous i_w_load and slot boundary: the new index uses the newly loaded shadow on the following cycle; no special priority.
- Invariant: $countones(~o_w_an) <= 1 at all times.

Decomposition:
- Shared package seg7_pkg:
  - Segment-pattern localparams SEG_0..SEG_F and SEG_OFF=7'h7F.
  - Function hex_to_seg(logic [3:0]) returning [6:0].
- One natural sub-module, seg7_prescaler: a PRESCALE-cycle counter with an o_w_tick output and a count output (needed for blanking).
- Decode stays in the top level via the package function.

Test Plan:
1. Reset, then deassert with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 -> o_w_an=4'b1111 and o_w_7seg=7'h7F during reset; first enabled anode is 4'b1110, three cycles after reset release.
2. Load data=16'hA5C0, dp=4'b0100, blank=0 -> the four slots show:
   - digit 0: an=1110, seg=100_0000
   - digit 1: an=1101, seg=100_0110
   - digit 2: an=1011, seg=001_0010, dp=0
   - digit 3: an=0111, seg=000_1000
   Each slot has 2 blank cycles; o_w_frame pulses once per 32 cycles.
3. Sweep nibbles 0-F on digit 0 -> o_w_7seg matches the decode table exactly for all 16 values.
4. blank=4'b1010 -> anodes 1 and 3 are never low; slot timing is unchanged (frame still 32 cycles).
5. Change i_w_data without i_w_load, then pulse i_w_load mid-slot -> display unchanged until the load; updated segments appear the cycle after the load, with no anode glitch.
6. Assert reset mid-slot of digit 2 -> outputs off the next cycle; after release, scanning restarts at digit 0 with the shadow cleared (shows "0" on every digit).
